// File: rtl/fix_msg_sequencer_pkg.sv
// fix_msg_sequencer_pkg: shared widths, state encoding and CheckSum tag constants
package fix_msg_sequencer_pkg;
    localparam int VALUE_DATA_WIDTH = 64;
    localparam int DEF_SIZE         = 64;
    localparam int DEF_TAG_WIDTH    = 32;
    localparam int DEF_TSIZE_W      = 5;

    // CheckSum(10) tag as ASCII "10" and its byte count
    localparam logic [31:0] T_CHECKSUM   = 32'h0000_3130;
    localparam logic [4:0]  S_T_CHECKSUM = 5'd2;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LEN_SCAN = 3'd1;
    localparam state_t ST_LEN_WAIT = 3'd2;
    localparam state_t ST_SEEK     = 3'd3;
    localparam state_t ST_TAG      = 3'd4;
    localparam state_t ST_VAL      = 3'd5;
    localparam state_t ST_CSUM     = 3'd6;
    localparam state_t ST_END_WAIT = 3'd7;
endpackage

// File: rtl/fix_msg_sequencer_if.sv
// fix_msg_sequencer_if: tag/value beat bus between sequencer and serializer
interface fix_msg_sequencer_if
    import fix_msg_sequencer_pkg::*;
#(
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int TSIZE_W     = DEF_TSIZE_W,
    parameter int VALUE_WIDTH = VALUE_DATA_WIDTH,
    parameter int SIZE        = DEF_SIZE
);
    logic [TAG_WIDTH-1:0]   tag_o;
    logic [TSIZE_W-1:0]     t_size_o;
    logic                   tag_valid_o;
    logic [VALUE_WIDTH-1:0] val_o;
    logic [SIZE-1:0]        v_size_o;
    logic                   val_valid_o;
    logic                   checksum_o;
    logic                   ready_i;
    logic                   end_i;

    modport master (
        output tag_o, t_size_o, tag_valid_o, val_o, v_size_o, val_valid_o, checksum_o,
        input  ready_i, end_i
    );
    modport slave (
        input  tag_o, t_size_o, tag_valid_o, val_o, v_size_o, val_valid_o, checksum_o,
        output ready_i, end_i
    );
endinterface

// File: rtl/fix_body_len_acc.sv
// fix_body_len_acc: saturating BodyLength accumulator with a sticky valid flag
module fix_body_len_acc
    import fix_msg_sequencer_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int AW    = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [AW-1:0]    add_val,
    input  logic             set_valid,
    input  logic             clr_valid,
    output logic [LEN_W-1:0] len,
    output logic             valid
);
    localparam int SW = AW + LEN_W;

    logic [SW-1:0] sum;

    // wide sum so any carry beyond LEN_W bits is visible for saturation
    always_comb sum = SW'(len) + SW'(add_val);

    // length register saturates at all-ones; clear wins over add, clr_valid over set_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            len   <= '0;
            valid <= 1'b0;
        end else begin
            if (clr) len <= '0;
            else if (add) len <= |sum[SW-1:LEN_W] ? '1 : sum[LEN_W-1:0];
            if (clr_valid) valid <= 1'b0;
            else if (set_valid) valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fix_msg_sequencer.sv
// fix_msg_sequencer: walks the field table, emits enabled tag/value beats, then CheckSum
module fix_msg_sequencer
    import fix_msg_sequencer_pkg::*;
#(
    parameter int VALUE_WIDTH  = VALUE_DATA_WIDTH,
    parameter int SIZE         = DEF_SIZE,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int TSIZE_W      = DEF_TSIZE_W,
    parameter int NUM_FIELDS   = 12,
    parameter int NUM_TYPES    = 4,
    parameter int BODY_LEN_IDX = 1,
    parameter int LEN_W        = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic [NUM_TYPES-1:0]              msg_type_i,
    input  logic [NUM_FIELDS*TAG_WIDTH-1:0]   field_tag_i,
    input  logic [NUM_FIELDS*TSIZE_W-1:0]     field_tsize_i,
    input  logic [NUM_FIELDS*VALUE_WIDTH-1:0] field_val_i,
    input  logic [NUM_FIELDS*SIZE-1:0]        field_vsize_i,
    input  logic [NUM_FIELDS*NUM_TYPES-1:0]   field_en_i,
    input  logic [VALUE_WIDTH-1:0]            bodylen_val_i,
    input  logic [SIZE-1:0]                   bodylen_vsize_i,
    input  logic                              bodylen_rdy_i,
    fix_msg_sequencer_if.master               bus,
    output logic [LEN_W-1:0]                  body_len_o,
    output logic                              body_len_valid_o,
    output logic [$clog2(NUM_FIELDS+1)-1:0]   field_idx_o,
    output logic                              busy_o,
    output logic                              err_o,
    output logic                              msg_creation_done_o
);
    localparam int IW = $clog2(NUM_FIELDS + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_FIELDS - 1);
    localparam logic [IW-1:0] NF   = IW'(NUM_FIELDS);
    localparam logic [IW-1:0] BLI  = IW'(BODY_LEN_IDX);

    state_t                 st;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          fi;
    logic [NUM_TYPES-1:0]   type_q;
    logic [NUM_FIELDS-1:0]  en;
    logic [TAG_WIDTH-1:0]   tags   [NUM_FIELDS];
    logic [TSIZE_W-1:0]     tsizes [NUM_FIELDS];
    logic [VALUE_WIDTH-1:0] vals   [NUM_FIELDS];
    logic [SIZE-1:0]        vsizes [NUM_FIELDS];
    logic                   start_ok;
    logic                   scan_add;
    logic                   scan_last;
    logic                   len_drop;
    logic [SIZE+1:0]        add_val;

    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_fld
        assign tags[f]   = field_tag_i[f*TAG_WIDTH +: TAG_WIDTH];
        assign tsizes[f] = field_tsize_i[f*TSIZE_W +: TSIZE_W];
        assign vals[f]   = field_val_i[f*VALUE_WIDTH +: VALUE_WIDTH];
        assign vsizes[f] = field_vsize_i[f*SIZE +: SIZE];
        assign en[f]     = |(field_en_i[f*NUM_TYPES +: NUM_TYPES] & type_q);
    end

    assign field_idx_o = idx;

    // table lookups use a clamped index so idx==NUM_FIELDS never reads past the table
    always_comb begin
        fi        = (idx < NF) ? idx : '0;
        start_ok  = (st == ST_IDLE) && start_i && !msg_creation_done_o && $onehot(msg_type_i);
        scan_add  = (st == ST_LEN_SCAN) && en[fi] && (idx > BLI);
        scan_last = (st == ST_LEN_SCAN) && (idx == LAST);
        len_drop  = ((st != ST_IDLE) && abort_i) || ((st == ST_END_WAIT) && bus.end_i);
        add_val   = (SIZE+2)'(tsizes[fi]) + (SIZE+2)'(vsizes[fi]) + (SIZE+2)'(2);
    end

    fix_body_len_acc #(.LEN_W(LEN_W), .AW(SIZE + 2)) u_len (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .add       (scan_add),
        .add_val   (add_val),
        .set_valid (scan_last),
        .clr_valid (len_drop),
        .len       (body_len_o),
        .valid     (body_len_valid_o)
    );

    // message FSM; beat registers load on entry and hold until the accepting cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            st                  <= ST_IDLE;
            idx                 <= '0;
            type_q              <= '0;
            busy_o              <= 1'b0;
            err_o               <= 1'b0;
            msg_creation_done_o <= 1'b0;
            bus.tag_o           <= '0;
            bus.t_size_o        <= '0;
            bus.tag_valid_o     <= 1'b0;
            bus.val_o           <= '0;
            bus.v_size_o        <= '0;
            bus.val_valid_o     <= 1'b0;
            bus.checksum_o      <= 1'b0;
        end else begin
            err_o               <= 1'b0;
            msg_creation_done_o <= 1'b0;
            if ((st != ST_IDLE) && abort_i) begin
                st              <= ST_IDLE;
                busy_o          <= 1'b0;
                bus.tag_valid_o <= 1'b0;
                bus.val_valid_o <= 1'b0;
                bus.checksum_o  <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (start_ok) begin
                            type_q <= msg_type_i;
                            idx    <= '0;
                            busy_o <= 1'b1;
                            st     <= ST_LEN_SCAN;
                        end else if (start_i && !msg_creation_done_o) begin
                            err_o <= 1'b1;
                        end
                    end
                    ST_LEN_SCAN: begin
                        if (idx == LAST) st <= ST_LEN_WAIT;
                        else idx <= idx + 1'b1;
                    end
                    ST_LEN_WAIT: begin
                        if (bodylen_rdy_i) begin
                            idx <= '0;
                            st  <= ST_SEEK;
                        end
                    end
                    ST_SEEK: begin
                        if (idx == NF) begin
                            bus.tag_o       <= TAG_WIDTH'(T_CHECKSUM);
                            bus.t_size_o    <= TSIZE_W'(S_T_CHECKSUM);
                            bus.tag_valid_o <= 1'b1;
                            bus.checksum_o  <= 1'b1;
                            st              <= ST_CSUM;
                        end else if (en[fi]) begin
                            bus.tag_o       <= tags[fi];
                            bus.t_size_o    <= tsizes[fi];
                            bus.tag_valid_o <= 1'b1;
                            st              <= ST_TAG;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    ST_TAG: begin
                        if (bus.ready_i) begin
                            bus.tag_valid_o <= 1'b0;
                            st              <= ST_VAL;
                        end
                    end
                    ST_VAL: begin
                        if (!bus.val_valid_o) begin
                            bus.val_valid_o <= 1'b1;
                            bus.val_o       <= (idx == BLI) ? bodylen_val_i : vals[fi];
                            bus.v_size_o    <= (idx == BLI) ? bodylen_vsize_i : vsizes[fi];
                        end else if (bus.ready_i) begin
                            bus.val_valid_o <= 1'b0;
                            idx             <= idx + 1'b1;
                            st              <= ST_SEEK;
                        end
                    end
                    ST_CSUM: begin
                        if (bus.ready_i) begin
                            bus.tag_valid_o <= 1'b0;
                            bus.checksum_o  <= 1'b0;
                            st              <= ST_END_WAIT;
                        end
                    end
                    ST_END_WAIT: begin
                        if (bus.end_i) begin
                            msg_creation_done_o <= 1'b1;
                            busy_o              <= 1'b0;
                            st                  <= ST_IDLE;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fix_msg_sequencer.sv
// tb_fix_msg_sequencer: directed checks of beat order, body length, stalls, abort and error
module tb_fix_msg_sequencer;
    import fix_msg_sequencer_pkg::*;

    localparam int NF = 12;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, bl_rdy = 1'b1;
    logic [3:0]       msg_type = '0;
    logic [NF*32-1:0] f_tag = '0;
    logic [NF*5-1:0]  f_ts = '0;
    logic [NF*64-1:0] f_val = '0;
    logic [NF*64-1:0] f_vs = '0;
    logic [NF*4-1:0]  f_en = '0;
    logic [63:0]      bl_val = 64'h3635;
    logic [63:0]      bl_vs = 64'd2;
    logic [15:0]      body_len;
    logic             blv, busy, err, done;
    logic [3:0]       fidx;
    int               n_cmp = 0, n_err = 0;

    int          tsz    [NF] = '{1, 1, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3};
    logic [63:0] vsz    [NF] = '{64'd7, 64'd3, 64'd1, 64'd6, 64'd3, 64'd1,
                                 64'd16, 64'd1, 64'd2, 64'd1, 64'd4, 64'd5};
    logic [3:0]  en_tab [NF] = '{4'b1011, 4'b1011, 4'b1011, 4'b0011, 4'b0011, 4'b0011,
                                 4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1010};

    fix_msg_sequencer_if bus ();

    fix_msg_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start),
        .abort_i             (abort),
        .msg_type_i          (msg_type),
        .field_tag_i         (f_tag),
        .field_tsize_i       (f_ts),
        .field_val_i         (f_val),
        .field_vsize_i       (f_vs),
        .field_en_i          (f_en),
        .bodylen_val_i       (bl_val),
        .bodylen_vsize_i     (bl_vs),
        .bodylen_rdy_i       (bl_rdy),
        .bus                 (bus),
        .body_len_o          (body_len),
        .body_len_valid_o    (blv),
        .field_idx_o         (fidx),
        .busy_o              (busy),
        .err_o               (err),
        .msg_creation_done_o (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int f = 0; f < NF; f++) begin
            f_tag[f*32 +: 32] = 32'h1000 + f;
            f_ts[f*5 +: 5]    = 5'(tsz[f]);
            f_val[f*64 +: 64] = 64'hF000 + 64'(f);
            f_vs[f*64 +: 64]  = vsz[f];
            f_en[f*4 +: 4]    = en_tab[f];
        end
    endtask

    task automatic run_msg(input string nm, input logic [3:0] ty, input int exp_len,
                           input logic [NF-1:0] mask, input int stall_f, input int bl_delay);
        logic [31:0] tq [$];
        logic [4:0]  tsq [$];
        logic [63:0] vq [$];
        logic [63:0] vsq [$];
        int          ef [$];
        logic [31:0] ctag = '0;
        logic [4:0]  csz = '0;
        logic [63:0] v0, s0;
        bit          csum = 0, stalled = 0, both = 0;
        int          wait_n = 0;
        for (int f = 0; f < NF; f++) if (mask[f]) ef.push_back(f);
        bl_rdy = (bl_delay == 0);
        msg_type = ty;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        for (int c = 0; c < 400 && !csum; c++) begin
            step();
            if (!bl_rdy && blv) begin
                chk({nm, "_lenwait_quiet"}, bus.tag_valid_o | bus.val_valid_o, 0);
                wait_n++;
                if (wait_n == bl_delay) bl_rdy = 1'b1;
            end
            if (bus.tag_valid_o && bus.val_valid_o) both = 1;
            if (stall_f >= 0 && !stalled && bus.val_valid_o && fidx == 4'(stall_f)) begin
                v0 = bus.val_o;
                s0 = bus.v_size_o;
                stalled = 1;
                bus.ready_i = 1'b0;
                repeat (3) begin
                    step();
                    chk({nm, "_stall_valid"}, bus.val_valid_o, 1);
                    chk({nm, "_stall_val"}, bus.val_o, v0);
                    chk({nm, "_stall_vsize"}, bus.v_size_o, s0);
                    chk({nm, "_stall_idx"}, fidx, 64'(stall_f));
                end
                bus.ready_i = 1'b1;
            end
            if (bus.tag_valid_o && bus.ready_i) begin
                if (bus.checksum_o) begin
                    csum = 1;
                    ctag = bus.tag_o;
                    csz  = bus.t_size_o;
                end else begin
                    tq.push_back(bus.tag_o);
                    tsq.push_back(bus.t_size_o);
                end
            end
            if (bus.val_valid_o && bus.ready_i) begin
                vq.push_back(bus.val_o);
                vsq.push_back(bus.v_size_o);
            end
        end
        chk({nm, "_csum_seen"}, csum, 1);
        chk({nm, "_csum_tag"}, ctag, 64'h3130);
        chk({nm, "_csum_tsize"}, csz, 2);
        chk({nm, "_overlap"}, both, 0);
        chk({nm, "_tag_beats"}, tq.size(), ef.size());
        chk({nm, "_val_beats"}, vq.size(), ef.size());
        if (stall_f >= 0) chk({nm, "_stall_seen"}, stalled, 1);
        if (bl_delay > 0) chk({nm, "_lenwait_cycles"}, wait_n, bl_delay);
        foreach (ef[i]) begin
            int f;
            f = ef[i];
            chk($sformatf("%s_tag%0d", nm, f), tq[i], 32'h1000 + f);
            chk($sformatf("%s_tsize%0d", nm, f), tsq[i], tsz[f]);
            chk($sformatf("%s_val%0d", nm, f), vq[i], f == 1 ? bl_val : 64'hF000 + 64'(f));
            chk($sformatf("%s_vsize%0d", nm, f), vsq[i], f == 1 ? bl_vs : vsz[f]);
        end
        chk({nm, "_body_len"}, body_len, exp_len);
        chk({nm, "_body_len_valid"}, blv, 1);
        step();
        chk({nm, "_csum_drop"}, bus.tag_valid_o | bus.checksum_o, 0);
        chk({nm, "_no_early_done"}, done, 0);
        bus.end_i = 1'b1;
        step();
        bus.end_i = 1'b0;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_blv_clr"}, blv, 0);
        step();
        chk({nm, "_done_pulse"}, done, 0);
        bl_rdy = 1'b1;
    endtask

    initial begin
        int n_done;
        bit found;
        bus.ready_i = 1'b1;
        bus.end_i   = 1'b0;
        pack();
        repeat (3) step();
        chk("rst_tag_valid", bus.tag_valid_o, 0);
        chk("rst_val_valid", bus.val_valid_o, 0);
        chk("rst_tag", bus.tag_o, 0);
        chk("rst_val", bus.val_o, 0);
        chk("rst_csum", bus.checksum_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_body_len", body_len, 0);
        chk("rst_blv", blv, 0);
        chk("rst_idx", fidx, 0);
        chk("rst_err_done", {err, done}, 0);
        rst = 1'b0;
        step();

        run_msg("logon", 4'b0001, 65, 12'h3FF, -1, 0);
        run_msg("hb", 4'b0010, 66, 12'hC7F, 5, 5);
        run_msg("empty", 4'b0100, 0, 12'h000, -1, 0);
        vsz[11] = 64'h1_0000_0000;
        pack();
        run_msg("sat", 4'b1000, 65535, 12'h807, -1, 0);
        vsz[11] = 64'd5;
        pack();

        msg_type = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        step();
        chk("err_one_cycle", err, 0);
        chk("err_still_idle", busy, 0);

        msg_type = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (bus.tag_valid_o && fidx == 4'd4) found = 1;
        end
        chk("abort_reach_f4", found, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_tag_valid", bus.tag_valid_o, 0);
        chk("abort_val_valid", bus.val_valid_o, 0);
        chk("abort_csum", bus.checksum_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_blv", blv, 0);
        n_done = 0;
        repeat (5) begin
            if (done) n_done++;
            step();
        end
        chk("abort_no_done", n_done, 0);
        run_msg("after_abort", 4'b0010, 66, 12'hC7F, -1, 0);

        msg_type = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        chk("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valids", bus.tag_valid_o | bus.val_valid_o, 0);
        chk("mid_rst_body_len", body_len, 0);
        chk("mid_rst_blv", blv, 0);
        chk("mid_rst_idx", fidx, 0);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fix_msg_sequencer.md
Name: fix_msg_sequencer

Overview:
Parametrised successor to the fixed-order FIX session message creator. It walks a table of NUM_FIELDS field descriptors and emits tag/value beats to the downstream serializer over a valid/ready handshake. A per-message-type enable mask selects which fields are emitted. A pre-pass computes the FIX BodyLength, and the block closes each message with the CheckSum tag.

Parameters:
VALUE_WIDTH, `VALUE_DATA_WIDTH, value bus width in bits
SIZE, 64, value byte-count width
TAG_WIDTH, 32, tag bus width
TSIZE_W, 5, tag byte-count width
NUM_FIELDS, 12, descriptor table depth
NUM_TYPES, 4, message types; msg_type_i is one-hot
BODY_LEN_IDX, 1, table index of BodyLength(9); fields with index > BODY_LEN_IDX count toward the length
LEN_W, 16, body length width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  begin message; ignored unless idle
abort_i  in  1  abandon current message
msg_type_i  in  NUM_TYPES  one-hot type, sampled on start
field_tag_i  in  NUM_FIELDS*TAG_WIDTH  tag of field f at slice f
field_tsize_i  in  NUM_FIELDS*TSIZE_W  tag byte counts
field_val_i  in  NUM_FIELDS*VALUE_WIDTH  values
field_vsize_i  in  NUM_FIELDS*SIZE  value byte counts
field_en_i  in  NUM_FIELDS*NUM_TYPES  bit f*NUM_TYPES+t enables field f for type t
bodylen_val_i  in  VALUE_WIDTH  ASCII body length from external converter
bodylen_vsize_i  in  SIZE  its byte count
bodylen_rdy_i  in  1  converter result valid
ready_i  in  1  downstream accepts current beat
end_i  in  1  downstream finished checksum
tag_o  out  TAG_WIDTH  tag beat
t_size_o  out  TSIZE_W  tag byte count
tag_valid_o  out  1  tag beat valid
val_o  out  VALUE_WIDTH  value beat
v_size_o  out  SIZE  value byte count
val_valid_o  out  1  value beat valid
checksum_o  out  1  high with the CheckSum tag beat
body_len_o  out  LEN_W  computed body length
body_len_valid_o  out  1  high from end of LEN_SCAN until idle
field_idx_o  out  $clog2(NUM_FIELDS+1)  current field index
busy_o  out  1  not idle
err_o  out  1  one-cycle pulse on a non-one-hot type at start
msg_creation_done_o  out  1  one-cycle done pulse

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Field inputs must stay stable from start until done; only msg_type is latched.
- States: IDLE, LEN_SCAN, LEN_WAIT, SEEK, TAG, VAL, CSUM, END_WAIT.
- IDLE: on start_i with a one-hot type, latch the type, clear idx and length, and go to LEN_SCAN. If the type is not one-hot, pulse err_o and stay in IDLE.
- LEN_SCAN: one field per cycle. If the field is enabled and idx > BODY_LEN_IDX, add tsize+vsize+2 (the '=' and SOH bytes). After idx NUM_FIELDS-1, set body_len_valid_o and go to LEN_WAIT.
- Length accumulation saturates at 2^LEN_W-1.
- LEN_WAIT: wait for bodylen_rdy_i, then idx=0 and go to SEEK.
- SEEK: if idx==NUM_FIELDS, go to CSUM. Else if the field is enabled, go to TAG. Else idx++ (one cycle per skipped field).
- TAG: tag_valid_o=1 with tag/t_size held stable until ready_i. On the accepting cycle, drop valid and go to VAL.
- VAL: val_valid_o=1 with val_o/v_size_o held stable. When idx==BODY_LEN_IDX, the value comes from bodylen_val_i/bodylen_vsize_i. On ready_i, idx++ and go to SEEK.
- Minimum spacing: one cycle from accept to next valid. tag_valid_o and val_valid_o are never high together.
- CSUM: tag `t_checksum/`s_t_checksum, tag_valid_o=1 and checksum_o=1 until ready_i, then go to END_WAIT.
- END_WAIT: on end_i, pulse msg_creation_done_o, clear body_len_valid_o, and go to IDLE.
- abort_i in any non-IDLE state: the next state is IDLE, all valids/checksum_o are cleared, and there is no done pulse. abort_i has priority over ready_i in the same cycle.
- start_i while busy is ignored. start_i in the done-pulse cycle is accepted only on the following cycle.
- Zero enabled fields: body_len_o=0 and SEEK goes directly to CSUM.
- rst mid-message: all outputs return to reset values next cycle.

Decomposition:
- Shared package holds the state enum, the `t_checksum/`s_t_checksum constants, and the field-descriptor slice widths.
- One sub-module, fix_body_len_acc: the saturating LEN_W accumulator with clear/add/valid.

Test Plan:
- Logon (type 4'b0001), 10 fields enabled, ready_i always 1 -> tag/value beats in table order, then the checksum beat with checksum_o=1. end_i -> one done pulse. body_len_o equals the hand-summed value, e.g. 65.
- Heartbeat (4'b0010) with fields 7-9 disabled -> those indices are skipped, no beats for them, and body_len_o excludes them.
- ready_i low for 3 cycles during a VAL beat -> val_o/v_size_o stable, val_valid_o held, no idx advance.
- bodylen_rdy_i delayed 5 cycles -> block stays in LEN_WAIT with no beats. The BodyLength beat carries bodylen_val_i.
- msg_type_i=4'b0011 at start -> err_o one-cycle pulse and busy_o stays 0.
- abort_i during field 4 TAG with ready_i=1 -> valids cleared next cycle, no done pulse, busy_o=0. A new start runs cleanly.
